// File: rtl/mult_2_stage_accum.sv
// Frame accumulator placed behind a one-register-stage multiplier: aligns issue flags with
// the registered product, sums each frame into a guard-extended accumulator, and holds results.
module mult_2_stage_accum #(
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int GUARD   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic                               in_last,
    input  logic                               in_tc,
    output logic                               in_ready,
    input  logic [A_width+B_width-1:0]         product,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [A_width+B_width+GUARD-1:0]   result,
    output logic [CNT_W-1:0]                   out_count,
    output logic                               out_ovf
);

    localparam int P_W   = A_width + B_width;
    localparam int ACC_W = P_W + GUARD;

    logic             s_vld;
    logic             s_last;
    logic             s_tc;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             frame_start;

    logic             issue;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_full;
    logic [ACC_W-1:0] sum;
    logic             step_ovf;
    logic             ovf_next;
    logic [CNT_W-1:0] count_base;
    logic [CNT_W-1:0] count_next;

    // A final term in the flag stage blocks issue so its product never meets a full result register.
    assign in_ready = !(s_vld && s_last) && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    assign ext        = s_tc ? {{GUARD{product[P_W-1]}}, product} : {{GUARD{1'b0}}, product};
    assign acc_base   = frame_start ? '0 : acc;
    assign sum_full   = {1'b0, acc_base} + {1'b0, ext};
    assign sum        = sum_full[ACC_W-1:0];
    assign step_ovf   = s_tc ? ((acc_base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_base[ACC_W-1]))
                             : sum_full[ACC_W];
    assign ovf_next   = (frame_start ? 1'b0 : ovf) | step_ovf;
    assign count_base = frame_start ? '0 : count;
    assign count_next = (&count_base) ? count_base : count_base + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld  <= 1'b0;
            s_last <= 1'b0;
            s_tc   <= 1'b0;
        end else begin
            s_vld  <= issue;
            s_last <= issue ? in_last : 1'b0;
            s_tc   <= issue ? in_tc : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            frame_start <= 1'b1;
        end else if (s_vld) begin
            if (s_last) begin
                acc         <= '0;
                count       <= '0;
                ovf         <= 1'b0;
                frame_start <= 1'b1;
            end else begin
                acc         <= sum;
                count       <= count_next;
                ovf         <= ovf_next;
                frame_start <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (s_vld && s_last) begin
            out_valid <= 1'b1;
            result    <= sum;
            out_count <= count_next;
            out_ovf   <= ovf_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
